bus_slave_ram: RTL and testbench
================================

# bus_slave_ram

Word-addressed, single-port RAM that acts as a responder on the CPU's shared bus. It services read and write transactions initiated by the MEM-stage bus interface: it samples chip select and address strobe, inserts a programmable number of wait states, performs the access, and pulses ready (active-low) for exactly one cycle. It sits behind the bus address decoder as one slave, and its read-data output is zero when idle so it can be OR-combined on the shared return path.

## Interface
- ADDR_W, 8: number of low word-address bits used; depth = 2^ADDR_W words.
- WAIT_CYC, 1: wait states inserted between request acceptance and the access cycle; legal range 0–15.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_cs_  in  1  chip select from address decoder, active-low.
- s_as_  in  1  address strobe from bus master, active-low.
- s_rw  in  1  1 = write (store), 0 = read (load).
- s_addr  in  30  word address; only [ADDR_W-1:0] used; upper bits ignored, so addresses alias.
- s_wr_data  in  32  write data.
- s_rd_data  out  32  read data; valid only in the ready cycle of a read, 0 at all other times.
- s_rdy_  out  1  ready, active-low, one-cycle pulse ending each completed transaction.
- s_busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, WAIT, ACCESS, READY.
- IDLE: if s_cs_=0 and s_as_=0 at a clock edge, latch s_addr[ADDR_W-1:0], s_rw and s_wr_data. Load the wait counter with WAIT_CYC. Go to WAIT if WAIT_CYC>0, otherwise go to ACCESS.
- WAIT: decrement the counter each cycle. When it reaches 0, go to ACCESS.
- WAIT abort: if s_cs_ or s_as_ is sampled high in WAIT, go to IDLE. No write, no s_rdy_ pulse.
- ACCESS: the RAM operation uses only the latched values.
  - Write: mem[addr] <= latched data at the end of the cycle.
  - Read: mem[addr] is registered into s_rd_data.
  - The access commits even if s_as_ deasserts during ACCESS. Go to READY.
- READY: s_rdy_=0. s_rd_data holds the read word for a read, or 0 for a write. Go to IDLE unconditionally.
- Bus rule: the master holds s_as_ low until it sees s_rdy_=0. If s_as_ is still low in the cycle after READY, that is taken as a new request.
- Inputs in ACCESS and READY are ignored. No request is queued while busy.
- Read-after-write to the same address returns the new data.
- s_rw is a single bit, so there is no illegal operation.

## Timing
- Reset (rst=1 at an edge) gives: state IDLE, s_rdy_=1, s_rd_data=0, s_busy=0, wait counter 0.
- RAM contents are not reset.
- Reset during any state abandons the transaction. A write not yet in ACCESS is not performed. A write in ACCESS at the same edge as rst is not performed.
- Latency: request sampled at edge of cycle 0, s_rdy_ low in cycle WAIT_CYC+2.
  - WAIT_CYC=0: ACCESS in cycle 1, READY in cycle 2.
  - WAIT_CYC=1: WAIT in cycle 1, ACCESS in cycle 2, READY in cycle 3.
- Back-to-back throughput: one transaction per WAIT_CYC+3 cycles.
- s_busy is high from cycle 1 through the READY cycle inclusive.
- All outputs are registered; there are no combinational input-to-output paths.
- Counter width is 4 bits. WAIT_CYC=15 gives exactly 15 WAIT cycles, with no wrap.

## Test plan
- Reset, WAIT_CYC=1: hold rst 2 cycles, then check s_rdy_=1, s_rd_data=0, s_busy=0. Write 0xDEADBEEF to addr 0x05. Check s_rdy_ low in cycle 3 only and s_rd_data=0. Read addr 0x05: s_rdy_ low in cycle 3 with s_rd_data=0xDEADBEEF, and s_rd_data=0 in cycles 2 and 4.
- Wait-state sweep, WAIT_CYC=0 and 15: for each, write then read addr 0xFF. Check s_rdy_ low in cycle 2 (WAIT_CYC=0) or cycle 17 (WAIT_CYC=15), and data 0x12345678 returned.
- Aliasing, ADDR_W=8: write 0xA5A5A5A5 to s_addr=0x105, then read s_addr=0x005. Required response: 0xA5A5A5A5.
- Abort in WAIT, WAIT_CYC=3: start a write of 0x11111111 to addr 0x10 over old value 0x0. Raise s_as_ in cycle 2. Required: no s_rdy_ pulse, s_busy drops next cycle, and a subsequent read of 0x10 returns 0x0.
- Chip select / busy: s_as_=0 with s_cs_=1 gives no response. A second request presented in WAIT is ignored. s_as_ held low after READY is accepted as a new request, with s_rdy_ again low WAIT_CYC+3 cycles after the first ready.
- Reset mid-transaction: assert rst in the ACCESS cycle of a write of 0xFFFFFFFF to addr 0x20 (old value 0x0). Required: s_rdy_ stays 1, outputs return to reset values, and a later read of 0x20 returns 0x0.

Source files
------------

// File: rtl/bus_slave_ram.sv
// Word-addressed single-port RAM slave on the shared CPU bus.
// It inserts programmable wait states and ends each transaction with a one-cycle active-low ready pulse.
module bus_slave_ram #(
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_cs_,
    input  logic        s_as_,
    input  logic        s_rw,
    input  logic [29:0] s_addr,
    input  logic [31:0] s_wr_data,
    output logic [31:0] s_rd_data,
    output logic        s_rdy_,
    output logic        s_busy
);

    // state  | meaning
    // IDLE   | waiting for cs_/as_ both low
    // WAIT   | counting wait states; a released strobe aborts
    // ACCESS | RAM read or write using only the latched request
    // READY  | s_rdy_ low for one cycle, read data presented
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_READY  = 2'd3;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

    logic [1:0]        state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [31:0]       data_q;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              req;
    logic              unused_addr;

    assign req = !s_cs_ && !s_as_;
    // Upper address bits are deliberately ignored so the RAM aliases.
    assign unused_addr = ^s_addr[29:ADDR_W];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    cnt_nxt   = WAIT_INIT;
                    state_nxt = (WAIT_INIT == 4'd0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: state_nxt = ST_READY;
            ST_READY:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            s_rdy_    <= 1'b1;
            s_rd_data <= '0;
            s_busy    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            s_busy <= (state_nxt != ST_IDLE);
            s_rdy_ <= (state_nxt != ST_READY);
            // Read data exists only during READY; zero otherwise for OR-combining.
            s_rd_data <= (state == ST_ACCESS && !rw_q) ? mem[addr_q] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == ST_IDLE && req) begin
            addr_q <= s_addr[ADDR_W-1:0];
            rw_q   <= s_rw;
            data_q <= s_wr_data;
        end
    end

    // A reset coinciding with ACCESS suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_ACCESS && rw_q)
            mem[addr_q] <= data_q;
    end

endmodule

// File: tb/tb_bus_slave_ram.sv
// Self-checking bench for bus_slave_ram: four instances cover wait counts 0, 1, 3 and 15.
// Expected ready latency and data are queued at request time and compared when ready appears.
module tb_bus_slave_ram;

    logic        clk;
    logic        rst;
    logic [3:0]  cs_;
    logic        s_as_;
    logic        s_rw;
    logic [29:0] s_addr;
    logic [31:0] s_wr_data;

    logic [31:0] rd_w0, rd_w1, rd_w3, rd_w15;
    logic        rdy_w0, rdy_w1, rdy_w3, rdy_w15;
    logic        busy_w0, busy_w1, busy_w3, busy_w15;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;
    exp_t sb[$];

    localparam int D_W0 = 0, D_W1 = 1, D_W3 = 2, D_W15 = 3;

    bus_slave_ram #(.ADDR_W(8), .WAIT_CYC(0)) u_w0 (
        .clk(clk), .rst(rst), .s_cs_(cs_[0]), .s_as_(s_as_), .s_rw(s_rw),
        .s_addr(s_addr), .s_wr_data(s_wr_data),
        .s_rd_data(rd_w0), .s_rdy_(rdy_w0), .s_busy(busy_w0));
    bus_slave_ram #(.ADDR_W(8), .WAIT_CYC(1)) u_w1 (
        .clk(clk), .rst(rst), .s_cs_(cs_[1]), .s_as_(s_as_), .s_rw(s_rw),
        .s_addr(s_addr), .s_wr_data(s_wr_data),
        .s_rd_data(rd_w1), .s_rdy_(rdy_w1), .s_busy(busy_w1));
    bus_slave_ram #(.ADDR_W(8), .WAIT_CYC(3)) u_w3 (
        .clk(clk), .rst(rst), .s_cs_(cs_[2]), .s_as_(s_as_), .s_rw(s_rw),
        .s_addr(s_addr), .s_wr_data(s_wr_data),
        .s_rd_data(rd_w3), .s_rdy_(rdy_w3), .s_busy(busy_w3));
    bus_slave_ram #(.ADDR_W(8), .WAIT_CYC(15)) u_w15 (
        .clk(clk), .rst(rst), .s_cs_(cs_[3]), .s_as_(s_as_), .s_rw(s_rw),
        .s_addr(s_addr), .s_wr_data(s_wr_data),
        .s_rd_data(rd_w15), .s_rdy_(rdy_w15), .s_busy(busy_w15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_rdy(input int d);
        case (d)
            D_W0:    return rdy_w0;
            D_W1:    return rdy_w1;
            D_W3:    return rdy_w3;
            default: return rdy_w15;
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            D_W0:    return busy_w0;
            D_W1:    return busy_w1;
            D_W3:    return busy_w3;
            default: return busy_w15;
        endcase
    endfunction

    function automatic logic [31:0] get_data(input int d);
        case (d)
            D_W0:    return rd_w0;
            D_W1:    return rd_w1;
            D_W3:    return rd_w3;
            default: return rd_w15;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus transaction on instance d. Latency counts cycles after the sampling edge (cycle 0).
    // hold keeps the strobe low past READY; cont continues straight from a held transaction.
    task automatic xact(input int d, input bit rw, input logic [29:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input int exp_lat, input bit hold, input bit cont,
                        input bit swap, input string tag);
        exp_t e;
        int   cyc;
        bit   got;
        if (!cont) begin
            @(posedge clk);
            #1;
        end
        cs_       = 4'hF;
        cs_[d]    = 1'b0;
        s_as_     = 1'b0;
        s_rw      = rw;
        s_addr    = addr;
        s_wr_data = wdata;
        e.data = exp_data;
        e.lat  = exp_lat;
        sb.push_back(e);
        if (cont) @(posedge clk);
        @(posedge clk);
        cyc = 1;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (get_rdy(d) == 1'b0) begin
                got = 1'b1;
                break;
            end
            chk({tag, "_rd_zero"}, get_data(d), 32'h0);
            if (swap && cyc == 1) begin
                s_addr    = addr ^ 30'h1;
                s_wr_data = ~wdata;
            end
            @(posedge clk);
            cyc++;
        end
        e = sb.pop_front();
        if (!got) begin
            chk({tag, "_timeout"}, 32'h0, 32'h1);
        end else begin
            chk({tag, "_lat"}, 32'(cyc), 32'(e.lat));
            chk({tag, "_data"}, get_data(d), e.data);
            chk({tag, "_busy"}, {31'b0, get_busy(d)}, 32'h1);
        end
        if (!hold) begin
            cs_   = 4'hF;
            s_as_ = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_post_rdy"}, {31'b0, get_rdy(d)}, 32'h1);
            chk({tag, "_post_rd"}, get_data(d), 32'h0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cs_       = 4'hF;
        s_as_     = 1'b1;
        s_rw      = 1'b0;
        s_addr    = '0;
        s_wr_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk("reset_rdy", {31'b0, get_rdy(d)}, 32'h1);
            chk("reset_rd", get_data(d), 32'h0);
            chk("reset_busy", {31'b0, get_busy(d)}, 32'h0);
        end

        xact(D_W1, 1'b1, 30'h05, 32'hDEADBEEF, 32'h0, 3, 0, 0, 0, "w1_wr");
        xact(D_W1, 1'b0, 30'h05, 32'h0, 32'hDEADBEEF, 3, 0, 0, 0, "w1_rd");

        xact(D_W0, 1'b1, 30'hFF, 32'h12345678, 32'h0, 2, 0, 0, 0, "w0_wr");
        xact(D_W0, 1'b0, 30'hFF, 32'h0, 32'h12345678, 2, 0, 0, 0, "w0_rd");
        xact(D_W15, 1'b1, 30'hFF, 32'h12345678, 32'h0, 17, 0, 0, 0, "w15_wr");
        xact(D_W15, 1'b0, 30'hFF, 32'h0, 32'h12345678, 17, 0, 0, 0, "w15_rd");

        xact(D_W1, 1'b1, 30'h105, 32'hA5A5A5A5, 32'h0, 3, 0, 0, 0, "alias_wr");
        xact(D_W1, 1'b0, 30'h005, 32'h0, 32'hA5A5A5A5, 3, 0, 0, 0, "alias_rd");

        // Abort in WAIT: strobe released during cycle 2
        xact(D_W3, 1'b1, 30'h10, 32'h0, 32'h0, 5, 0, 0, 0, "abort_init");
        @(posedge clk);
        #1;
        cs_[2]    = 1'b0;
        s_as_     = 1'b0;
        s_rw      = 1'b1;
        s_addr    = 30'h10;
        s_wr_data = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_c1", {31'b0, busy_w3}, 32'h1);
        @(posedge clk);
        #1;
        s_as_ = 1'b1;
        cs_   = 4'hF;
        for (int c = 3; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_no_rdy", {31'b0, rdy_w3}, 32'h1);
            if (c == 3) chk("abort_busy_drop", {31'b0, busy_w3}, 32'h0);
        end
        xact(D_W3, 1'b0, 30'h10, 32'h0, 32'h0, 5, 0, 0, 0, "abort_rd");

        // Strobe without chip select
        @(posedge clk);
        #1;
        cs_    = 4'hF;
        s_as_  = 1'b0;
        s_rw   = 1'b0;
        s_addr = 30'h05;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            chk("nocs_rdy", {31'b0, rdy_w1}, 32'h1);
            chk("nocs_busy", {31'b0, busy_w1}, 32'h0);
        end
        s_as_ = 1'b1;

        // A changed request during WAIT is ignored
        xact(D_W3, 1'b1, 30'h41, 32'h0, 32'h0, 5, 0, 0, 0, "ign_init");
        xact(D_W3, 1'b1, 30'h40, 32'hCAFE0001, 32'h0, 5, 0, 0, 1, "ign_wr");
        xact(D_W3, 1'b0, 30'h40, 32'h0, 32'hCAFE0001, 5, 0, 0, 0, "ign_rd_a");
        xact(D_W3, 1'b0, 30'h41, 32'h0, 32'h0, 5, 0, 0, 0, "ign_rd_b");

        // Strobe held past READY starts the next transaction at once
        xact(D_W1, 1'b1, 30'h30, 32'h0BADF00D, 32'h0, 3, 1, 0, 0, "b2b_wr");
        xact(D_W1, 1'b0, 30'h30, 32'h0, 32'h0BADF00D, 3, 0, 1, 0, "b2b_rd");

        // Reset in the ACCESS cycle of a write
        xact(D_W1, 1'b1, 30'h20, 32'h0, 32'h0, 3, 0, 0, 0, "rst_init");
        @(posedge clk);
        #1;
        cs_[1]    = 1'b0;
        s_as_     = 1'b0;
        s_rw      = 1'b1;
        s_addr    = 30'h20;
        s_wr_data = 32'hFFFFFFFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        s_as_ = 1'b1;
        cs_   = 4'hF;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_rdy", {31'b0, rdy_w1}, 32'h1);
        chk("rst_mid_rd", rd_w1, 32'h0);
        chk("rst_mid_busy", {31'b0, busy_w1}, 32'h0);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_after_rdy", {31'b0, rdy_w1}, 32'h1);
        end
        xact(D_W1, 1'b0, 30'h20, 32'h0, 32'h0, 3, 0, 0, 0, "rst_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
